// File: rtl/demux18_tdm.sv
// Receive side of the 8:1 TDM link: tracks the slot index of a serial line and
// rebuilds the 8-bit channel word, either double-buffered or updated per slot.
module demux18_tdm #(
   parameter int UPDATE_MODE = 0,
   parameter int SYNC_CHECK  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       x,
   input  logic       en,
   input  logic       sync,
   output logic [2:0] s,
   output logic [7:0] o,
   output logic       valid,
   output logic       err
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam bit PER_SLOT   = (UPDATE_MODE != 0);
   localparam bit CHECK_SYNC = (SYNC_CHECK != 0);

   state_t     state, state_nxt;
   logic [2:0] s_nxt;
   logic [7:0] shadow, shadow_nxt;
   logic [7:0] o_nxt;
   logic       valid_nxt;
   logic       err_nxt;
   logic       realign;

   // A sync away from slot 0 abandons the partial frame, including at slot 7,
   // so valid and err can never fire together.
   assign realign = sync && (s != 3'd0) && CHECK_SYNC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         s      <= 3'd0;
         shadow <= 8'h00;
         o      <= 8'h00;
         valid  <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         s      <= s_nxt;
         shadow <= shadow_nxt;
         o      <= o_nxt;
         valid  <= valid_nxt;
         err    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      s_nxt      = s;
      shadow_nxt = shadow;
      o_nxt      = o;
      valid_nxt  = 1'b0;
      err_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (en && sync) begin
               shadow_nxt[0] = x;
               s_nxt         = 3'd1;
               state_nxt     = RUN;
               if (PER_SLOT) o_nxt[0] = x;
            end
         end

         RUN: begin
            if (en) begin
               if (realign) begin
                  shadow_nxt = {7'b0, x};
                  s_nxt      = 3'd1;
                  err_nxt    = 1'b1;
                  if (PER_SLOT) o_nxt[0] = x;
               end else begin
                  shadow_nxt[s] = x;
                  if (PER_SLOT) o_nxt[s] = x;
                  if (s == 3'd7) begin
                     // Double-buffered mode publishes the whole frame at once.
                     if (!PER_SLOT) o_nxt = shadow_nxt;
                     valid_nxt = 1'b1;
                     s_nxt     = 3'd0;
                  end else begin
                     s_nxt = s + 3'd1;
                  end
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_demux18_tdm.sv
// Bench for demux18_tdm: three parameterisations share one stimulus stream and
// are checked against hand tables and a frame-level reference model.
module tb_demux18_tdm;

   localparam int N = 3;
   localparam int MODE_OF [N] = '{0, 1, 0};
   localparam int CHK_OF  [N] = '{1, 1, 0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       x = 1'b0;
   logic       en = 1'b0;
   logic       sync = 1'b0;
   logic [2:0] s_w     [N];
   logic [7:0] o_w     [N];
   logic       valid_w [N];
   logic       err_w   [N];

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   demux18_tdm #(.UPDATE_MODE(0), .SYNC_CHECK(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .x(x), .en(en), .sync(sync),
      .s(s_w[0]), .o(o_w[0]), .valid(valid_w[0]), .err(err_w[0]));
   demux18_tdm #(.UPDATE_MODE(1), .SYNC_CHECK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .x(x), .en(en), .sync(sync),
      .s(s_w[1]), .o(o_w[1]), .valid(valid_w[1]), .err(err_w[1]));
   demux18_tdm #(.UPDATE_MODE(0), .SYNC_CHECK(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .x(x), .en(en), .sync(sync),
      .s(s_w[2]), .o(o_w[2]), .valid(valid_w[2]), .err(err_w[2]));

   // Frame-level reference: is the receiver aligned, which slot comes next,
   // which bits of the current frame have arrived, and what word is published.
   typedef struct {
      bit       aligned;
      int       slot;
      bit [7:0] partial;
      bit [7:0] word;
      bit       valid;
      bit       err;
   } model_t;

   model_t mdl [N];

   typedef struct {
      bit       en;
      bit       sync;
      bit       x;
      int       exp_s;
      bit [7:0] exp_o;
      bit       exp_valid;
      bit       exp_err;
   } vec_t;

   vec_t vecs [$];

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mdl[i].aligned = 0;
         mdl[i].slot    = 0;
         mdl[i].partial = 8'h00;
         mdl[i].word    = 8'h00;
         mdl[i].valid   = 0;
         mdl[i].err     = 0;
      end
   endtask

   task automatic modelStep(input bit e, input bit sy, input bit xb);
      for (int i = 0; i < N; i++) begin
         mdl[i].valid = 0;
         mdl[i].err   = 0;
         if (!e) continue;
         if (!mdl[i].aligned) begin
            if (sy) begin
               mdl[i].aligned    = 1;
               mdl[i].partial[0] = xb;
               mdl[i].slot       = 1;
               if (MODE_OF[i] == 1) mdl[i].word[0] = xb;
            end
         end else if (sy && mdl[i].slot != 0 && CHK_OF[i] == 1) begin
            mdl[i].partial = {7'b0, xb};
            mdl[i].slot    = 1;
            mdl[i].err     = 1;
            if (MODE_OF[i] == 1) mdl[i].word[0] = xb;
         end else begin
            mdl[i].partial[mdl[i].slot] = xb;
            if (MODE_OF[i] == 1) mdl[i].word[mdl[i].slot] = xb;
            if (mdl[i].slot == 7) begin
               if (MODE_OF[i] == 0) mdl[i].word = mdl[i].partial;
               mdl[i].valid = 1;
               mdl[i].slot  = 0;
            end else begin
               mdl[i].slot = mdl[i].slot + 1;
            end
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkModel();
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("model s[%0d]", i), {5'b0, s_w[i]}, 8'(mdl[i].slot));
         checkOutput($sformatf("model o[%0d]", i), o_w[i], mdl[i].word);
         checkOutput($sformatf("model valid[%0d]", i), {7'b0, valid_w[i]}, {7'b0, mdl[i].valid});
         checkOutput($sformatf("model err[%0d]", i), {7'b0, err_w[i]}, {7'b0, mdl[i].err});
      end
   endtask

   // Drive inputs away from the rising edge, advance one clock, then sample on
   // the falling edge.
   task automatic applyStimulus(input bit e, input bit sy, input bit xb);
      en   = e;
      sync = sy;
      x    = xb;
      @(posedge clk);
      modelStep(e, sy, xb);
      @(negedge clk);
   endtask

   task automatic asyncReset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("%s s[%0d]", tag, i), {5'b0, s_w[i]}, 8'h00);
         checkOutput($sformatf("%s o[%0d]", tag, i), o_w[i], 8'h00);
         checkOutput($sformatf("%s valid[%0d]", tag, i), {7'b0, valid_w[i]}, 8'h00);
         checkOutput($sformatf("%s err[%0d]", tag, i), {7'b0, err_w[i]}, 8'h00);
      end
      modelReset();
      en   = 1'b0;
      sync = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic void addVec(input bit e, input bit sy, input bit xb, input int es,
                                  input bit [7:0] eo, input bit ev, input bit ee);
      vec_t v;
      v.en = e; v.sync = sy; v.x = xb; v.exp_s = es;
      v.exp_o = eo; v.exp_valid = ev; v.exp_err = ee;
      vecs.push_back(v);
   endfunction

   function automatic void addFrame(input bit [7:0] w, input bit sync_first, input bit [7:0] prev);
      for (int k = 0; k < 8; k++)
         addVec(1'b1, sync_first && k == 0, w[k], (k + 1) % 8,
                (k == 7) ? w : prev, k == 7, 1'b0);
   endfunction

   initial begin
      bit [7:0] tw;
      bit [7:0] rw;

      // Expectations below are for the double-buffered, sync-checking instance.
      addFrame(8'h4D, 1'b1, 8'h00);
      addFrame(8'hA5, 1'b0, 8'h4D);
      addFrame(8'h3C, 1'b0, 8'hA5);
      tw = 8'h96;
      for (int k = 0; k < 8; k++) begin
         addVec(1'b1, k == 0, tw[k], (k + 1) % 8, (k == 7) ? tw : 8'h3C, k == 7, 1'b0);
         addVec(1'b0, 1'b0, ~tw[k], (k + 1) % 8, (k == 7) ? tw : 8'h3C, 1'b0, 1'b0);
      end
      addVec(1, 1, 1, 1, 8'h96, 0, 0);
      addVec(1, 0, 0, 2, 8'h96, 0, 0);
      addVec(1, 0, 1, 3, 8'h96, 0, 0);
      addVec(1, 1, 0, 1, 8'h96, 0, 1);
      rw = 8'h1E;
      for (int k = 1; k < 8; k++)
         addVec(1, 0, rw[k], (k + 1) % 8, (k == 7) ? rw : 8'h96, k == 7, 0);
      for (int k = 0; k < 7; k++)
         addVec(1, 0, 1, k + 1, 8'h1E, 0, 0);
      addVec(1, 1, 1, 1, 8'h1E, 0, 1);

      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset o0", o_w[0], 8'h00);
      checkOutput("reset s0", {5'b0, s_w[0]}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Unaligned input is ignored until the first sync.
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 1);
      checkOutput("idle s0", {5'b0, s_w[0]}, 8'h00);
      checkModel();

      foreach (vecs[n]) begin
         applyStimulus(vecs[n].en, vecs[n].sync, vecs[n].x);
         checkOutput($sformatf("vec%0d s", n), {5'b0, s_w[0]}, 8'(vecs[n].exp_s));
         checkOutput($sformatf("vec%0d o", n), o_w[0], vecs[n].exp_o);
         checkOutput($sformatf("vec%0d valid", n), {7'b0, valid_w[0]}, {7'b0, vecs[n].exp_valid});
         checkOutput($sformatf("vec%0d err", n), {7'b0, err_w[0]}, {7'b0, vecs[n].exp_err});
         checkModel();
      end

      asyncReset("midframe reset");

      // Per-slot mode fills an all-ones frame one bit per enabled slot.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, k == 0, 1);
         checkOutput($sformatf("walk%0d o1", k), o_w[1], 8'((16'd1 << (k + 1)) - 1));
         checkOutput($sformatf("walk%0d valid1", k), {7'b0, valid_w[1]}, {7'b0, k == 7});
         checkModel();
      end
      applyStimulus(0, 0, 0);
      checkOutput("hold o1", o_w[1], 8'hFF);
      checkOutput("hold o0", o_w[0], 8'hFF);

      for (int c = 0; c < 600; c++) begin
         applyStimulus($urandom_range(3, 0) != 0, $urandom_range(11, 0) == 0, 1'($urandom));
         checkModel();
         if (c == 300) asyncReset("random reset");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
